// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default field widths
// and the EX->MEM payload layout at those default widths.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned CTRL_W_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam int unsigned CTRL_MEM_READ   = 0;
    localparam int unsigned CTRL_MEM_WRITE  = 1;
    localparam int unsigned CTRL_REG_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] alu;
        logic [REG_W_DEF-1:0]  rd;
        logic [REG_W_DEF-1:0]  rt;
        logic [DATA_W_DEF-1:0] dato_b;
        logic [CTRL_W_DEF-1:0] ctrl;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry (main + skid) pipeline register with valid/ready handshake
// and synchronous flush. State advances on the falling clock edge.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         acc;
    logic         pop;

    assign acc = in_valid & ready_q;
    assign pop = main_valid_q & out_ready;

    // Next-state: flush wins, then fill/refill main, overflow into skid.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (acc) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                main_d       = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: packs the EX fields into a skid register and
// counts (saturating) the cycles MEM holds off a valid entry.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_dato_b,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rt,
    output logic [DATA_W-1:0] out_dato_b,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] dato_b;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    localparam int unsigned     PAYLOAD_W = $bits(payload_t);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    payload_t         in_pl;
    payload_t         out_pl;
    logic [CNT_W-1:0] stall_q;

    always_comb begin
        in_pl        = '0;
        in_pl.alu    = in_alu;
        in_pl.rd     = in_rd;
        in_pl.rt     = in_rt;
        in_pl.dato_b = in_dato_b;
        in_pl.ctrl   = in_ctrl;
    end

    pipe_skid_reg #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    // Backpressure counter; a flushed edge is not a stall.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_alu     = out_pl.alu;
    assign out_rd      = out_pl.rd;
    assign out_rt      = out_pl.rt;
    assign out_dato_b  = out_pl.dato_b;
    assign out_ctrl    = out_pl.ctrl;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed pushes queue expected payloads,
// a monitor compares on every MEM-side handshake.
module tb_ex_mem_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu;
    logic [4:0]  in_rd;
    logic [4:0]  in_rt;
    logic [31:0] in_dato_b;
    logic [3:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic [4:0]  out_rd;
    logic [4:0]  out_rt;
    logic [31:0] out_dato_b;
    logic [3:0]  out_ctrl;
    logic [15:0] stall_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_alu;
    logic [4:0]  sat_out_rd;
    logic [4:0]  sat_out_rt;
    logic [31:0] sat_out_dato_b;
    logic [3:0]  sat_out_ctrl;
    logic [3:0]  sat_stall_count;

    int checks;
    int failures;
    ex_mem_payload_t exp_q[$];

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_rd(in_rd), .in_rt(in_rt), .in_dato_b(in_dato_b),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_rd(out_rd), .out_rt(out_rt), .out_dato_b(out_dato_b),
        .out_ctrl(out_ctrl), .stall_count(stall_count)
    );

    ex_mem_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_alu(in_alu), .in_rd(in_rd), .in_rt(in_rt), .in_dato_b(in_dato_b),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_alu(sat_out_alu), .out_rd(sat_out_rd), .out_rt(sat_out_rt),
        .out_dato_b(sat_out_dato_b), .out_ctrl(sat_out_ctrl), .stall_count(sat_stall_count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance past the next active (falling) edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic [4:0] rt,
                         input logic [31:0] db, input logic [3:0] ctrl, input bit expect_acc);
        ex_mem_payload_t p;
        in_valid  = 1'b1;
        in_alu    = alu;
        in_rd     = rd;
        in_rt     = rt;
        in_dato_b = db;
        in_ctrl   = ctrl;
        p.alu = alu; p.rd = rd; p.rt = rt; p.dato_b = db; p.ctrl = ctrl;
        if (expect_acc) exp_q.push_back(p);
    endtask

    // Monitor: a handshake is committed on the falling edge after this rising-edge sample.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            ex_mem_payload_t got;
            got.alu = out_alu; got.rd = out_rd; got.rt = out_rt;
            got.dato_b = out_dato_b; got.ctrl = out_ctrl;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 128'(1), 128'(0));
            end else begin
                check("pop_payload", 128'(got), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ctrl5;
        checks = 0;
        failures = 0;
        ctrl5 = 4'((1 << CTRL_MEM_READ) | (1 << CTRL_REG_WRITE));
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_alu = '0; in_rd = '0; in_rt = '0; in_dato_b = '0; in_ctrl = '0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset then idle
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_alu", 128'(out_alu), 128'(0));
        check("rst_out_rd", 128'(out_rd), 128'(0));
        check("rst_out_rt", 128'(out_rt), 128'(0));
        check("rst_out_dato_b", 128'(out_dato_b), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_stall", 128'(stall_count), 128'(0));

        // Single pass
        out_ready = 1'b1;
        drive(32'h0000_1234, 5'd3, 5'd7, 32'hDEAD_BEEF, ctrl5, 1'b1);
        step();
        in_valid = 1'b0;
        check("pass_out_valid", 128'(out_valid), 128'(1));
        check("pass_out_ctrl", 128'(out_ctrl), 128'(5));
        step();
        check("pass_drain_valid", 128'(out_valid), 128'(0));
        check("pass_hold_alu", 128'(out_alu), 128'(32'h1234));
        check("pass_in_ready", 128'(in_ready), 128'(1));

        // Backpressure with skid fill and drain
        out_ready = 1'b0;
        drive(32'h11, 5'd1, 5'd2, 32'hA, 4'h1, 1'b1);
        step();
        check("bp_a_valid", 128'(out_valid), 128'(1));
        check("bp_a_alu", 128'(out_alu), 128'(32'h11));
        check("bp_a_ready", 128'(in_ready), 128'(1));
        check("bp_a_stall", 128'(stall_count), 128'(0));
        drive(32'h22, 5'd4, 5'd5, 32'hB, 4'h2, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp_b_ready", 128'(in_ready), 128'(0));
        check("bp_b_alu", 128'(out_alu), 128'(32'h11));
        check("bp_b_stall", 128'(stall_count), 128'(1));
        step();
        check("bp_hold_stall", 128'(stall_count), 128'(2));
        out_ready = 1'b1;
        step();
        check("bp_b_out", 128'(out_alu), 128'(32'h22));
        check("bp_b_valid", 128'(out_valid), 128'(1));
        check("bp_drain_ready", 128'(in_ready), 128'(1));
        check("bp_drain_stall", 128'(stall_count), 128'(2));
        step();
        check("bp_empty", 128'(out_valid), 128'(0));

        // Flush with both entries full
        out_ready = 1'b0;
        drive(32'h44, 5'd6, 5'd7, 32'hD, 4'h4, 1'b1);
        step();
        drive(32'h55, 5'd8, 5'd9, 32'hE, 4'h8, 1'b1);
        step();
        check("fl_full_ready", 128'(in_ready), 128'(0));
        check("fl_full_stall", 128'(stall_count), 128'(3));
        flush = 1'b1;
        drive(32'h33, 5'd10, 5'd11, 32'hC, 4'h3, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_ready", 128'(in_ready), 128'(1));
        check("fl_stall", 128'(stall_count), 128'(3));
        check("fl_hold_alu", 128'(out_alu), 128'(32'h44));
        step();
        check("fl_c_dropped", 128'(out_valid), 128'(0));

        // Flush while ready: the offered input is dropped
        drive(32'h66, 5'd12, 5'd13, 32'hF, 4'h6, 1'b1);
        step();
        flush = 1'b1;
        drive(32'h77, 5'd14, 5'd15, 32'h10, 4'h7, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("fl2_valid", 128'(out_valid), 128'(0));
        check("fl2_alu", 128'(out_alu), 128'(32'h66));
        check("fl2_stall", 128'(stall_count), 128'(3));

        // Asynchronous reset mid-stall
        drive(32'h88, 5'd16, 5'd17, 32'h11, 4'h9, 1'b1);
        step();
        drive(32'h99, 5'd18, 5'd19, 32'h12, 4'hA, 1'b1);
        step();
        in_valid = 1'b0;
        check("ar_pre_stall", 128'(stall_count), 128'(4));
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 128'(out_valid), 128'(0));
        check("ar_stall", 128'(stall_count), 128'(0));
        check("ar_ready", 128'(in_ready), 128'(1));
        check("ar_alu", 128'(out_alu), 128'(0));
        reset = 1'b0;
        exp_q.delete();
        step();

        // Saturation on the 4-bit counter instance
        drive(32'hAB, 5'd20, 5'd21, 32'h13, 4'hB, 1'b1);
        step();
        in_valid = 1'b0;
        repeat (15) step();
        check("sat_at_15", 128'(sat_stall_count), 128'(15));
        check("wide_at_15", 128'(stall_count), 128'(15));
        repeat (5) step();
        check("sat_held", 128'(sat_stall_count), 128'(15));
        check("wide_at_20", 128'(stall_count), 128'(20));
        out_ready = 1'b1;
        step();
        check("sat_drain_valid", 128'(out_valid), 128'(0));
        check("sat_drain_stall", 128'(stall_count), 128'(20));
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX→MEM pipeline boundary register with valid/ready handshake. Replaces fixed-width enable-gated latching and its tri-state output on stall.
- Holds its contents and applies backpressure to EX through a two-entry skid buffer (main plus skid).
- Supports a synchronous flush for branch/exception squash and counts backpressure cycles.
- Sits between the ALU/EX stage and the data-memory stage.

Parameters:
- DATA_W, 32, width of the ALU result and store-data (dato_B) fields
- REG_W, 5, width of the rd/rt register-address fields
- CTRL_W, 4, width of the opaque control bundle (mem_read, mem_write, reg_write, mem_to_reg), passed through unchanged
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, like the other pipeline stages
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_alu  in  DATA_W  ALU result
- in_rd  in  REG_W  destination register
- in_rt  in  REG_W  rt register
- in_dato_b  in  DATA_W  store data
- in_ctrl  in  CTRL_W  control bundle
- flush  in  1  squash all held entries
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM accepts the entry
- out_alu, out_rd, out_rt, out_dato_b, out_ctrl  out  widths as inputs  fields of the main entry
- stall_count  out  CNT_W  saturating count of backpressure cycles

Behaviour:
- State: main entry {valid, fields}; skid entry {valid, fields}. The outputs are the main entry fields directly, with no combinational path from input to output.
- Outputs are never driven to Z. Invalid entries keep their last field values.
- Reset (async, asserted): main_valid=0, skid_valid=0, all fields=0, stall_count=0, so out_valid=0 and in_ready=1. Deassertion takes effect at the next falling edge.
- Events at each falling edge:
  - acc = in_valid & in_ready
  - pop = out_valid & out_ready
- Flush has priority over everything:
  - main_valid and skid_valid go to 0.
  - acc is ignored and the input is dropped. EX must treat a flushed cycle as consumed.
  - stall_count is not incremented.
  - Fields hold their values.
- Otherwise, in priority order:
  - Main empty, acc → main loads the input. Latency is one falling edge.
  - Main full, pop, skid full → main loads skid; skid_valid=0. acc is impossible here because in_ready=0.
  - Main full, pop, skid empty, acc → main loads the input (simultaneous pop and push).
  - Main full, pop, no acc → main_valid=0.
  - Main full, no pop, acc → skid loads the input; skid_valid=1, so in_ready=0 next cycle.
  - No acc, no pop → hold.
- The skid buffer is never filled while main is empty. An entry never bypasses an older entry, so order is FIFO.
- stall_count increments by 1 on each edge with out_valid & !out_ready & !flush. It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-transfer: state is lost immediately and no output glitches to X.

Decomposition:
- Shared package pipe_pkg holds:
  - the control-bundle bit positions (CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_REG_WRITE=2, CTRL_MEM_TO_REG=3)
  - the ex_mem_payload_t struct {alu, rd, rt, dato_b, ctrl}
  - the default width constants
- One natural sub-module: pipe_skid_reg. It is a generic payload-width two-entry skid register with flush, and later stages can reuse it. ex_mem_stage wraps it and adds field packing and the stall counter.

Test Plan:
- Reset then idle:
  - Stimulus: reset high, then low, in_valid=0.
  - Response: out_valid=0, in_ready=1, all outputs 0, stall_count=0.
- Single pass:
  - Stimulus: in_valid=1, in_alu=0x0000_1234, rd=3, rt=7, dato_b=0xDEAD_BEEF, ctrl=0x5, out_ready=1.
  - Response: after one falling edge, out_valid=1 with the same fields. The next edge with in_valid=0 gives out_valid=0.
- Backpressure:
  - Stimulus: out_ready=0, push A=0x11 then B=0x22.
  - Response: out=A, in_ready=0 after B, stall_count increments each edge.
  - Then out_ready=1: A pops, B appears next edge, then in_ready=1.
- Flush:
  - Stimulus: main and skid both full, flush=1 with in_valid=1, C=0x33.
  - Response: next edge out_valid=0, in_ready=1, C is not captured, stall_count is unchanged on that edge.
- Async reset mid-stall:
  - Stimulus: main and skid full, reset pulsed between edges.
  - Response: out_valid=0 and stall_count=0 immediately, with no clock edge needed.
- Saturation:
  - Stimulus: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 edges.
  - Response: stall_count stops at 15.
